sample_writer: RTL and testbench
================================

Name: sample_writer

Overview:
- Write-side address generator and controller for the dual-port sample RAM; counterpart of the read-address counter that replays stored waveforms.
- Accepts a valid/ready sample stream and produces the RAM write strobe, address and data.
- Supports a single-shot fill or a continuous circular write.
- Exports the live write pointer and a primed flag, so the read side can trail it at a fixed offset.

Parameters:
- ADDR_WIDTH, 8: RAM address bits; buffer depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8: sample width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; when low, in_ready is low and the FSM holds.
- start  input  1  one-cycle pulse; begins a capture from IDLE; ignored in other states.
- stop  input  1  one-cycle pulse; aborts FILL/RUN and returns to IDLE.
- mode  input  1  0 = single-shot, 1 = continuous; sampled only when start is accepted.
- in_valid  input  1  input sample valid.
- in_data  input  DATA_WIDTH  input sample.
- in_ready  output  1  combinational; high in FILL or RUN when en=1.
- wr_en  output  1  RAM write strobe, registered.
- wr_addr  output  ADDR_WIDTH  RAM write address, registered.
- wr_data  output  DATA_WIDTH  RAM write data, registered.
- wr_ptr  output  ADDR_WIDTH  next address to be written.
- primed  output  1  high once the full buffer has been written since the last start.
- busy  output  1  high in FILL or RUN.
- done  output  1  one-cycle pulse when a single-shot fill completes.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, wr_ptr=0, primed=0, busy=0, done=0; in_ready=0.
- Accept: accept = in_valid & in_ready.
- Write pipeline: each accept drives wr_en=1, wr_addr=wr_ptr, wr_data=in_data on the next edge (latency 1). wr_ptr increments on the same edge, modulo 2^ADDR_WIDTH with natural wrap. wr_en=0 on cycles with no accept.
- FSM states: IDLE, FILL, RUN.
- IDLE:
  - start=1 and en=1 -> FILL; wr_ptr cleared to 0; primed cleared; mode latched.
  - start with en=0 is ignored.
- FILL, accept while wr_ptr = 2^ADDR_WIDTH-1 (last slot):
  - primed set on that edge.
  - Latched mode=0 -> IDLE, done=1 for one cycle on that edge.
  - Latched mode=1 -> RUN.
- RUN: circular writes; wr_ptr wraps 2^ADDR_WIDTH-1 -> 0; primed stays 1; never self-terminates.
- stop in FILL/RUN -> IDLE on the next edge.
  - A sample accepted in the same cycle is still written.
  - done is not pulsed.
  - primed and wr_ptr are retained.
- stop in IDLE: ignored. start in FILL/RUN: ignored.
- Simultaneous stop and last-slot accept in FILL with mode=0: sample written, primed=1, done=1, state IDLE.
- en=0 mid-capture: in_ready=0, no writes; state, wr_ptr and primed are frozen.
- busy is registered and equals (state is FILL or RUN).
- Reset asserted mid-operation: all outputs return to reset values immediately; any in-flight write is dropped.

Optional Feature:
- Macro: SAMPLE_WRITER_DECIM_EN.
- When defined:
  - Adds port decim (input, 4 bits).
  - Only every (decim+1)-th accepted sample is written; the first accept after start is always written.
  - in_ready behaviour is unchanged; non-written accepts are consumed and discarded.
  - The decimation counter clears on start and on reset.
  - decim=0 behaves identically to the macro being undefined.
- When undefined: no decim port; every accepted sample is written.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=8):
- Reset/idle: hold rst_n=0, then release with in_valid=1 and no start -> in_ready=0, wr_en never 1, all outputs 0.
- Single-shot fill: start with mode=0, then in_valid=1 continuously with data 0x10..0x1F -> wr_addr 0..15 each 1 cycle after accept, wr_data matches; done pulses once on the 16th write edge; primed=1, busy=0, state IDLE.
- Continuous wrap: start with mode=1, then 20 samples -> addresses 0..15,0..3; primed rises on the 16th write; wr_ptr=4; busy=1; no done.
- Backpressure/enable: in FILL, toggle en low for 3 cycles with in_valid=1 -> in_ready=0 and no wr_en for those cycles; wr_ptr unchanged; writes resume at the same address.
- Stop collision: in RUN, assert stop with an in_valid accept -> that sample written at the current wr_ptr; IDLE next edge; wr_ptr retained; no done; a new start clears wr_ptr to 0 and primed to 0.
- Async reset mid-fill: drop rst_n between clock edges at wr_ptr=7 -> outputs zero immediately without waiting for a clock edge; with SAMPLE_WRITER_DECIM_EN and decim=2, a restarted capture writes samples 0, 3 and 6 of the input stream to addresses 0, 1 and 2.

Source files
------------

// File: rtl/sample_writer.sv
// Write-side address generator for the dual-port sample RAM: single-shot or circular capture.
// Optional decimation of the accepted stream is enabled with `define SAMPLE_WRITER_DECIM_EN.
module sample_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
`ifdef SAMPLE_WRITER_DECIM_EN
    input  logic [3:0]            decim,
`endif
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic                  primed,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic                  primed_q, primed_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept, wr_fire, last_slot;
`ifdef SAMPLE_WRITER_DECIM_EN
    logic [3:0]            dcnt_q, dcnt_d;
`endif

    always_comb begin
        in_ready  = en && (state_q == FILL || state_q == RUN);
        accept    = in_valid && in_ready;
        last_slot = (wr_ptr_q == {ADDR_WIDTH{1'b1}});
`ifdef SAMPLE_WRITER_DECIM_EN
        // Only the first of every decim+1 accepts reaches the RAM; the rest are dropped.
        wr_fire = accept && (dcnt_q == 4'd0);
        dcnt_d  = dcnt_q;
        if (accept) dcnt_d = (dcnt_q == decim) ? 4'd0 : dcnt_q + 4'd1;
`else
        wr_fire = accept;
`endif
        state_d   = state_q;
        mode_d    = mode_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;
        primed_d  = primed_q;
        done_d    = 1'b0;

        if (wr_fire) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = in_data;
            wr_ptr_d  = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start && en) begin
                    state_d  = FILL;
                    wr_ptr_d = '0;
                    primed_d = 1'b0;
                    mode_d   = mode;
`ifdef SAMPLE_WRITER_DECIM_EN
                    dcnt_d   = 4'd0;
`endif
                end
            end
            FILL: begin
                if (wr_fire && last_slot) begin
                    primed_d = 1'b1;
                    if (mode_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (stop && en) state_d = IDLE;
            end
            RUN: begin
                if (stop && en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_ptr_q  <= '0;
            primed_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SAMPLE_WRITER_DECIM_EN
            dcnt_q    <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_ptr_q  <= wr_ptr_d;
            primed_q  <= primed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SAMPLE_WRITER_DECIM_EN
            dcnt_q    <= dcnt_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_ptr  = wr_ptr_q;
    assign primed  = primed_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sample_writer.sv
// Randomized + directed bench for sample_writer against a capture-level reference model.
// Build with SAMPLE_WRITER_DECIM_EN to exercise decimation as well.
module tb_sample_writer;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [3:0]    decim = 4'd0;
    logic          in_ready, wr_en, primed, busy, done;
    logic [AW-1:0] wr_addr, wr_ptr;
    logic [DW-1:0] wr_data;

    sample_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop), .mode(mode),
`ifdef SAMPLE_WRITER_DECIM_EN
        .decim(decim),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ptr(wr_ptr),
        .primed(primed), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a capture is "active" until a single-shot fill finishes or stop arrives.
    bit     m_active, m_cont, m_primed;
    int     m_ptr, m_cnt;
    bit     e_wr_en, e_done;
    int     e_addr, e_data;

    task automatic model_reset();
        m_active = 0; m_cont = 0; m_primed = 0; m_ptr = 0; m_cnt = 0;
        e_wr_en = 0; e_done = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic model_step();
        bit rdy, acc, wr;
        int dv;
        dv  = 0;
`ifdef SAMPLE_WRITER_DECIM_EN
        dv  = int'(decim);
`endif
        rdy = en && m_active;
        acc = in_valid && rdy;
        wr  = acc && (m_cnt == 0);
        e_wr_en = wr;
        e_done  = 0;
        if (wr) begin
            e_addr = m_ptr;
            e_data = int'(in_data);
        end
        if (acc) m_cnt = (m_cnt == dv) ? 0 : m_cnt + 1;
        if (!m_active) begin
            if (start && en) begin
                m_active = 1; m_cont = mode; m_ptr = 0; m_primed = 0; m_cnt = 0;
            end
        end else begin
            if (wr) begin
                if (m_ptr == DEPTH - 1) begin
                    m_primed = 1;
                    if (!m_cont) begin
                        m_active = 0;
                        e_done = 1;
                    end
                end
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            if (stop && en) m_active = 0;
        end
    endtask

    // One clock: check in_ready mid-cycle, advance model, compare registered outputs after the edge.
    task automatic cycle();
        @(negedge clk);
        chk("in_ready", in_ready, en && m_active);
        model_step();
        @(posedge clk);
        #1;
        chk("wr_en", wr_en, e_wr_en);
        chk("wr_addr", wr_addr, e_addr);
        chk("wr_data", wr_data, e_data);
        chk("wr_ptr", wr_ptr, m_ptr);
        chk("primed", primed, m_primed);
        chk("busy", busy, m_active);
        chk("done", done, e_done);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_wr_ptr"}, wr_ptr, 0);
        chk({tag, "_primed"}, primed, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic pulse_start(input logic m);
        start = 1; mode = m; in_valid = 0;
        cycle();
        start = 0;
    endtask

    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_data = DW'(base + i);
            cycle();
        end
        in_valid = 0;
    endtask

    int done_cnt;

    initial begin
        model_reset();
        #12;
        check_zero("rst_hold");
        // Release reset with traffic present but no start
        @(negedge clk);
        rst_n = 1; en = 1; in_valid = 1; in_data = 8'hAA;
        for (int i = 0; i < 3; i++) cycle();

        // Single-shot fill
        pulse_start(0);
        done_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = DW'(8'h10 + i);
            cycle();
            if (done) done_cnt++;
        end
        in_valid = 0;
        chk("fill_done_count", done_cnt, 1);
        chk("fill_last_addr", wr_addr, DEPTH - 1);
        chk("fill_primed", primed, 1);
        chk("fill_busy", busy, 0);
        cycle();

        // Continuous wrap
        pulse_start(1);
        feed(20, 8'h40);
        chk("wrap_ptr", wr_ptr, 4);
        chk("wrap_busy", busy, 1);
        chk("wrap_primed", primed, 1);

        // Stop colliding with an accept in RUN
        stop = 1; in_valid = 1; in_data = 8'hC3;
        cycle();
        stop = 0; in_valid = 0;
        chk("stop_addr", wr_addr, 4);
        chk("stop_data", wr_data, 8'hC3);
        chk("stop_ptr", wr_ptr, 5);
        chk("stop_busy", busy, 0);
        cycle();
        pulse_start(0);
        chk("restart_ptr", wr_ptr, 0);
        chk("restart_primed", primed, 0);

        // Enable low for three cycles mid-fill
        feed(5, 8'h60);
        en = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'(8'h70 + i);
            cycle();
        end
        chk("en_hold_ptr", wr_ptr, 5);
        en = 1;
        feed(2, 8'h80);
        chk("en_resume_addr", wr_addr, 6);

        // Asynchronous reset between edges at wr_ptr = 7
        chk("pre_rst_ptr", wr_ptr, 7);
        #3 rst_n = 0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1;

`ifdef SAMPLE_WRITER_DECIM_EN
        decim = 4'd2;
        pulse_start(0);
        feed(9, 8'h00);
        chk("decim_ptr", wr_ptr, 3);
        chk("decim_last_data", wr_data, 8'h06);
`endif

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            start    = ($urandom_range(0, 24) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            mode     = $urandom_range(0, 1);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DW'($urandom);
`ifdef SAMPLE_WRITER_DECIM_EN
            if ($urandom_range(0, 49) == 0) decim = 4'($urandom_range(0, 3));
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
